// File: rtl/word_memory_bank.sv
// word_memory_bank: DEPTH x WIDTH word store with a registered read port, a clear sweep, and optional write-first bypass (WORD_MEMORY_BANK_BYPASS_EN).
module word_memory_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     clear,
  output logic                     busy
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic idle_go, wr_ok, rd_ok, rd_in;
  logic [WIDTH-1:0] rd_word;
  assign busy    = state == S_CLEAR;
  assign idle_go = state == S_IDLE && !clear && !reset;
  assign wr_ok   = idle_go && wr_en && {1'b0, wr_addr} < DEPTH_W;
  assign rd_ok   = idle_go && rd_en;
  assign rd_in   = {1'b0, rd_addr} < DEPTH_W;
`ifdef WORD_MEMORY_BANK_BYPASS_EN
  assign rd_word = !rd_in ? '0 : (wr_ok && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
`else
  assign rd_word = rd_in ? mem[rd_addr] : '0;
`endif
  // next-state: the sweep walks idx up to LAST, clear restarts it from IDLE
  always_comb begin
    state_d = state;
    idx_d   = idx;
    if (state == S_CLEAR) begin
      state_d = idx == LAST ? S_IDLE : S_CLEAR;
      idx_d   = idx == LAST ? '0 : idx + 1'b1;
    end else if (clear) begin
      state_d = S_CLEAR;
      idx_d   = '0;
    end
  end
  // state, sweep index and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CLEAR;
      idx      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      rd_valid <= rd_ok;
      if (rd_ok) rd_data <= rd_word;
    end
  end
  // array writes: sweep has sole ownership while busy, otherwise the write port
  always_ff @(posedge clk) begin
    if (busy && !reset) mem[idx] <= RESET_VAL;
    else if (wr_ok) mem[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_word_memory_bank.sv
// tb_word_memory_bank: directed checks of sweep, read/write, collision, clear lockout, mid-sweep reset and out-of-range access.
module tb_word_memory_bank;
  logic clk = 0, reset = 1;
  logic wr_en = 0, rd_en = 0, clear = 0;
  logic [3:0] wr_addr = 0, rd_addr = 0;
  logic [7:0] wr_data = 0, rd_data;
  logic rd_valid, busy;
  logic w12_en = 0, r12_en = 0, c12 = 0;
  logic [3:0] w12_addr = 0, r12_addr = 0;
  logic [7:0] w12_data = 0, r12_data;
  logic r12_valid, b12;
  int checks = 0, failures = 0;
  int n;
  logic seen;
  logic [7:0] coll_exp;
  word_memory_bank #(.WIDTH(8), .DEPTH(16), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clear(clear), .busy(busy));
  word_memory_bank #(.WIDTH(8), .DEPTH(12), .RESET_VAL(8'h00)) u12 (
    .clk(clk), .reset(reset), .wr_en(w12_en), .wr_addr(w12_addr), .wr_data(w12_data),
    .rd_en(r12_en), .rd_addr(r12_addr), .rd_data(r12_data), .rd_valid(r12_valid),
    .clear(c12), .busy(b12));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    rd_en = 1; rd_addr = a;
    tick();
    rd_en = 0;
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
  endtask
  task automatic busy_len(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (rd_valid) seen = 1;
      tick();
    end
  endtask
  task automatic rd12(input string tag, input logic [3:0] a, input logic [7:0] exp);
    r12_en = 1; r12_addr = a;
    tick();
    r12_en = 0;
    chk({tag, "_valid"}, r12_valid, 1);
    chk({tag, "_data"}, r12_data, exp);
  endtask
  initial begin
    tick();
    chk("rst_busy", busy, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 0);
    reset = 0;
    seen = 0;
    busy_len(n);
    chk("rst_busy_len", n, 16);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1; rd_addr = 4'(i);
      tick();
      chk("sweep_valid", rd_valid, 1);
      chk("sweep_data", rd_data, 0);
    end
    rd_en = 0;
    tick();
    chk("sweep_valid_drop", rd_valid, 0);
    wr(3, 8'hA5);
    wr(15, 8'h3C);
    rd_en = 1; rd_addr = 3;
    tick();
    chk("b2b_valid0", rd_valid, 1);
    chk("b2b_data0", rd_data, 8'hA5);
    rd_addr = 15;
    tick();
    chk("b2b_valid1", rd_valid, 1);
    chk("b2b_data1", rd_data, 8'h3C);
    rd_en = 0;
    tick();
    chk("b2b_valid_drop", rd_valid, 0);
    chk("b2b_hold", rd_data, 8'h3C);
    wr(5, 8'h11);
`ifdef WORD_MEMORY_BANK_BYPASS_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    wr_en = 1; wr_addr = 5; wr_data = 8'h22; rd_en = 1; rd_addr = 5;
    tick();
    wr_en = 0; rd_en = 0;
    chk("coll_data", rd_data, coll_exp);
    rd("coll_after", 5, 8'h22);
    wr_en = 1; wr_addr = 6; wr_data = 8'h44; rd_en = 1; rd_addr = 3;
    tick();
    wr_en = 0; rd_en = 0;
    chk("diff_rd", rd_data, 8'hA5);
    rd("diff_wr", 6, 8'h44);
    wr(7, 8'h5A);
    rd("pre_clear7", 7, 8'h5A);
    clear = 1; wr_en = 1; wr_addr = 7; wr_data = 8'hFF; rd_en = 1; rd_addr = 3;
    tick();
    clear = 0; wr_addr = 7; wr_data = 8'hEE;
    chk("clr_valid_first", rd_valid, 0);
    seen = 0;
    busy_len(n);
    wr_en = 0; rd_en = 0;
    chk("clr_busy_len", n, 16);
    chk("clr_no_valid", seen, 0);
    chk("clr_hold", rd_data, 8'h5A);
    rd("clr_w7", 7, 8'h00);
    rd("clr_w3", 3, 8'h00);
    rd("clr_w15", 15, 8'h00);
    wr(9, 8'h99);
    clear = 1;
    tick();
    clear = 0;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_busy_pre", busy, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_data", rd_data, 0);
    busy_len(n);
    chk("mid_busy_len", n, 16);
    rd("mid_w9", 9, 8'h00);
    w12_en = 1; w12_addr = 11; w12_data = 8'hBB;
    tick();
    w12_addr = 13; w12_data = 8'h77;
    tick();
    w12_en = 0;
    rd12("oor_w11a", 11, 8'hBB);
    rd12("oor_r13", 13, 8'h00);
    rd12("oor_w11b", 11, 8'hBB);
    rd12("oor_w1", 1, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
